// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign FIX cycle).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;
  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] diff;

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  // done stays in busy so a start during the done cycle is not taken
  assign busy        = (state_q != S_IDLE) || done_q;
  assign accept      = start && !busy;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // The bit shifted out of R is kept so divisors above 2^(WIDTH-1) still work;
  // when ge is set the difference is below the divisor and fits in WIDTH bits.
  assign rs   = {r_q, q_q[WIDTH-1]};
  assign ge   = (rs >= {1'b0, dvsr_q});
  assign diff = rs[WIDTH-1:0] - dvsr_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dbz_d  = 1'b0;
          dvsr_d = b_mag;
          step_d = '0;
`ifdef DIV_SIGNED_EN
          negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negr_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = dividend;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = a_mag;
            r_d     = '0;
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_d    = ge ? diff : rs[WIDTH-1:0];
        q_d    = {q_q[WIDTH-2:0], ge};
        step_d = step_q + 1'b1;
        if (step_q == LAST) begin
`ifdef DIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        q_d     = negq_q ? (~q_q + 1'b1) : q_q;
        r_d     = negr_q ? (~r_q + 1'b1) : r_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        quo_d   = q_q;
        rem_d   = r_q;
        dbz_d   = dz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (unsigned default, signed vectors under DIV_SIGNED_EN).
module tb_seq_divider;
  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic         clock = 1'b0;
  logic         clear, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;
  int           n_chk = 0;
  int           n_err = 0;
  int           lat;
  logic         seen;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // returns #1 after the accepting edge (edge 0)
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int elat);
    int l;
    issue(a, b);
    check({tag, ".busy0"}, 64'(busy), 64'd1);
    wait_done(l);
    check({tag, ".lat"}, 64'(l), 64'(elat));
    check({tag, ".q"}, 64'(quotient), 64'(eq));
    check({tag, ".r"}, 64'(remainder), 64'(er));
    check({tag, ".dz"}, 64'(div_by_zero), 64'(edz));
    tick();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    check({tag, ".q_hold"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.q", 64'(quotient), 64'd0);
    check("rst.r", 64'(remainder), 64'd0);
    check("rst.dz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    run("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);

    // start held high across the first op: second accepted only once idle
    @(negedge clock);
    start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    tick();
    dividend = 32'h0000_002A; divisor = 32'h0000_003A;
    wait_done(lat);
    check("b2b1.lat", 64'(lat), 64'(LAT));
    check("b2b1.q", 64'(quotient), 64'hFFFF_FFFF);
    check("b2b1.r", 64'(remainder), 64'd0);
    tick();
    check("b2b1.idle", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    wait_done(lat);
    check("b2b2.lat", 64'(lat), 64'(LAT));
    check("b2b2.q", 64'(quotient), 64'd0);
    check("b2b2.r", 64'(remainder), 64'd42);
    tick();

    // divide by zero
    issue(32'd42, 32'd0);
    check("dz.busy0", 64'(busy), 64'd1);
    check("dz.done0", 64'(done), 64'd0);
    wait_done(lat);
    check("dz.lat", 64'(lat), 64'd1);
    check("dz.flag", 64'(div_by_zero), 64'd1);
    check("dz.q", 64'(quotient), 64'hFFFF_FFFF);
    check("dz.r", 64'(remainder), 64'd42);
    tick();
    check("dz.idle", 64'(busy), 64'd0);
    check("dz.done_pulse", 64'(done), 64'd0);

    // ignored start while busy, then abort by clear
    issue(32'd100, 32'd7);
    check("ab.dz_cleared", 64'(div_by_zero), 64'd0);
    repeat (9) tick();
    @(negedge clock);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick();
    start = 1'b0;
    check("ab.busy10", 64'(busy), 64'd1);
    check("ab.q_hold", 64'(quotient), 64'hFFFF_FFFF);
    repeat (10) tick();
    clear = 1'b1;
    #1;
    check("ab.busy", 64'(busy), 64'd0);
    check("ab.done", 64'(done), 64'd0);
    check("ab.q", 64'(quotient), 64'd0);
    check("ab.r", 64'(remainder), 64'd0);
    check("ab.dz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check("ab.no_done", 64'(seen), 64'd0);
    run("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);

`ifdef DIV_SIGNED_EN
    run("sn100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT);
    run("s100_n7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, LAT);
    run("smin_n1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT);
    run("sn1_big", 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 1'b0, LAT);
`else
    run("u_bigdiv", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, LAT);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
